// File: rtl/mem_access_stage.sv
// MEM stage of a 5-stage MIPS pipeline: word-addressed data memory with a multi-cycle
// access latency, registered MEM/WB outputs and a stall request while an access is in flight.
module mem_access_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        wb_in,
  input  logic        mem2reg_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  dst_addr_in,
  output logic        stall,
  output logic        valid_out,
  output logic        wb_out,
  output logic        mem2reg_out,
  output logic [31:0] mem_read_data_out,
  output logic [31:0] ALU_result_out,
  output logic [4:0]  dst_addr_out,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  // Handshake: the EX/MEM slot is consumed on any rising edge where stall is low
  // and valid_in is high; upstream must hold its slot while stall is high.
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        req_rd, req_wr, req_wb, req_m2r;
  logic [31:0] req_addr, req_data;
  logic [4:0]  req_dst;
  logic [31:0] mem [DEPTH_WORDS];

  logic        op_rd, op_wr, op_wb, op_m2r, op_mem, op_mis;
  logic [31:0] op_addr, op_data;
  logic [4:0]  op_dst;
  logic [AW-1:0] op_idx;
  logic        complete, do_store, is_load;

  assign stall = (state == BUSY);

  // The operation being finished comes straight from the inputs when idle,
  // otherwise from the request captured at acceptance.
  always_comb begin
    op_rd   = mem_read;
    op_wr   = mem_write;
    op_wb   = wb_in;
    op_m2r  = mem2reg_in;
    op_addr = ALU_result_in;
    op_data = write_data_in;
    op_dst  = dst_addr_in;
    if (state == BUSY) begin
      op_rd   = req_rd;
      op_wr   = req_wr;
      op_wb   = req_wb;
      op_m2r  = req_m2r;
      op_addr = req_addr;
      op_data = req_data;
      op_dst  = req_dst;
    end
  end

  assign op_mem   = op_rd | op_wr;
  assign op_mis   = op_mem && (op_addr[1:0] != 2'b00);
  assign op_idx   = op_addr[AW+1:2];
  assign do_store = op_wr && !op_mis;
  assign is_load  = op_rd && !op_wr && !op_mis;

  always_comb begin
    complete = 1'b0;
    if (state == IDLE)
      complete = valid_in && (!op_mem || MEM_LATENCY == 1);
    else
      complete = (cnt == 4'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= 4'd0;
      req_rd            <= 1'b0;
      req_wr            <= 1'b0;
      req_wb            <= 1'b0;
      req_m2r           <= 1'b0;
      req_addr          <= 32'd0;
      req_data          <= 32'd0;
      req_dst           <= 5'd0;
      valid_out         <= 1'b0;
      wb_out            <= 1'b0;
      mem2reg_out       <= 1'b0;
      mem_read_data_out <= 32'd0;
      ALU_result_out    <= 32'd0;
      dst_addr_out      <= 5'd0;
      misalign_err      <= 1'b0;
    end else begin
      valid_out         <= 1'b0;
      wb_out            <= 1'b0;
      mem2reg_out       <= 1'b0;
      mem_read_data_out <= 32'd0;
      ALU_result_out    <= 32'd0;
      dst_addr_out      <= 5'd0;
      misalign_err      <= 1'b0;
      if (complete) begin
        valid_out         <= 1'b1;
        wb_out            <= op_wb;
        mem2reg_out       <= op_m2r;
        mem_read_data_out <= is_load ? mem[op_idx] : 32'd0;
        ALU_result_out    <= op_addr;
        dst_addr_out      <= op_dst;
        misalign_err      <= op_mis;
      end
      case (state)
        IDLE: begin
          if (valid_in && op_mem && MEM_LATENCY > 1) begin
            state    <= BUSY;
            cnt      <= LAT_M1;
            req_rd   <= mem_read;
            req_wr   <= mem_write;
            req_wb   <= wb_in;
            req_m2r  <= mem2reg_in;
            req_addr <= ALU_result_in;
            req_data <= write_data_in;
            req_dst  <= dst_addr_in;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store commits on the completion edge, so a later load's read sees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else if (complete && do_store) begin
      mem[op_idx] <= op_data;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: unit 0 runs MEM_LATENCY=2, unit 1 runs MEM_LATENCY=4.
// Directed instructions push expected MEM/WB results; a negedge monitor pops and compares.
module tb_mem_access_stage;

  localparam int W = 76;  // {wb, mem2reg, data, alu, dst, misalign, stall_cycles}

  logic        clk;
  logic        rst        [2];
  logic        valid_in   [2];
  logic        mem_read   [2];
  logic        mem_write  [2];
  logic        wb_in      [2];
  logic        mem2reg_in [2];
  logic [31:0] alu_in     [2];
  logic [31:0] wdata_in   [2];
  logic [4:0]  dst_in     [2];
  wire         stall      [2];
  wire         valid_out  [2];
  wire         wb_out     [2];
  wire         m2r_out    [2];
  wire  [31:0] data_out   [2];
  wire  [31:0] alu_out    [2];
  wire  [4:0]  dst_out    [2];
  wire         mis_out    [2];

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int total = 0;
  int bad = 0;
  int stall_cnt [2];
  bit mon_en = 0;

  for (genvar g = 0; g < 2; g++) begin : u
    mem_access_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(g == 0 ? 2 : 4)) dut (
      .clk(clk), .rst(rst[g]), .valid_in(valid_in[g]), .mem_read(mem_read[g]),
      .mem_write(mem_write[g]), .wb_in(wb_in[g]), .mem2reg_in(mem2reg_in[g]),
      .ALU_result_in(alu_in[g]), .write_data_in(wdata_in[g]), .dst_addr_in(dst_in[g]),
      .stall(stall[g]), .valid_out(valid_out[g]), .wb_out(wb_out[g]),
      .mem2reg_out(m2r_out[g]), .mem_read_data_out(data_out[g]),
      .ALU_result_out(alu_out[g]), .dst_addr_out(dst_out[g]), .misalign_err(mis_out[g])
    );
  end

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // driver: present one instruction, hold it until consumed (edge with stall low)
  task automatic issue(input int un, input logic rd, input logic wr, input logic wb,
                       input logic m2r, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] dst, input logic [31:0] xdata, input logic xmis,
                       input bit push);
    logic [3:0] xst;
    logic [W-1:0] e;
    xst = (rd | wr) ? ((un == 0) ? 4'd1 : 4'd3) : 4'd0;
    e = {wb, m2r, xdata, alu, dst, xmis, xst};
    valid_in[un] = 1'b1;
    mem_read[un] = rd;
    mem_write[un] = wr;
    wb_in[un] = wb;
    mem2reg_in[un] = m2r;
    alu_in[un] = alu;
    wdata_in[un] = wd;
    dst_in[un] = dst;
    if (push) begin
      if (un == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
    end
    for (int k = 0; k < 40 && stall[un]; k++) @(negedge clk);
    if (stall[un]) begin
      total++;
      bad++;
      $display("FAIL accept timeout u%0d: stall=%b want=0", un, stall[un]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int un);
    valid_in[un] = 1'b0;
    mem_read[un] = 1'b0;
    mem_write[un] = 1'b0;
    wb_in[un] = 1'b0;
    mem2reg_in[un] = 1'b0;
    alu_in[un] = 32'd0;
    wdata_in[un] = 32'd0;
    dst_in[un] = 5'd0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) begin
        logic [W-1:0] got;
        logic [W-1:0] want;
        if (rst[k]) begin
          stall_cnt[k] = 0;
        end else begin
          if (stall[k]) stall_cnt[k]++;
          got = {wb_out[k], m2r_out[k], data_out[k], alu_out[k], dst_out[k], mis_out[k],
                 4'(stall_cnt[k])};
          if (valid_out[k]) begin
            if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
              total++;
              bad++;
              $display("FAIL u%0d unexpected valid_out: got=%h want=none", k, got);
            end else begin
              want = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              check($sformatf("u%0d result", k), got, want);
            end
            stall_cnt[k] = 0;
          end else begin
            check($sformatf("u%0d bubble", k), {got[W-1:4], 4'd0}, '0);
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1;
      stall_cnt[k] = 0;
      idle(k);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    mon_en = 1;
    check("reset stall u0", {75'd0, stall[0]}, '0);
    check("reset valid u1", {75'd0, valid_out[1]}, '0);

    // unit 0, latency 2
    issue(0, 0, 0, 1, 0, 32'h0000_1234, 32'd0, 5'd5, 32'd0, 0, 1);   // add
    idle(0);
    @(negedge clk);
    issue(0, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0, 32'd0, 0, 1);    // sw
    issue(0, 1, 0, 1, 1, 32'h10, 32'd0, 5'd8, 32'hDEADBEEF, 0, 1);    // lw
    issue(0, 1, 0, 1, 1, 32'h13, 32'd0, 5'd9, 32'd0, 1, 1);           // lw misaligned
    issue(0, 0, 1, 0, 0, 32'h20, 32'hCAFEF00D, 5'd0, 32'd0, 0, 1);
    issue(0, 0, 1, 0, 0, 32'h22, 32'h11111111, 5'd0, 32'd0, 1, 1);    // sw misaligned
    issue(0, 1, 0, 1, 1, 32'h20, 32'd0, 5'd10, 32'hCAFEF00D, 0, 1);
    issue(0, 0, 1, 0, 0, 32'h400, 32'h55, 5'd0, 32'd0, 0, 1);         // wraps to word 0
    issue(0, 1, 0, 1, 1, 32'h000, 32'd0, 5'd11, 32'h55, 0, 1);
    issue(0, 1, 1, 0, 0, 32'h30, 32'h77, 5'd12, 32'd0, 0, 1);         // rd+wr acts as store
    issue(0, 0, 0, 1, 0, 32'hABCD, 32'd0, 5'd13, 32'd0, 0, 1);
    issue(0, 1, 0, 1, 1, 32'h30, 32'd0, 5'd14, 32'h77, 0, 1);
    idle(0);

    // unit 1, latency 4: reset aborts an in-flight store
    issue(1, 0, 1, 0, 0, 32'h0C, 32'hAAAA5555, 5'd0, 32'd0, 0, 0);
    idle(1);
    rst[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("rst mid-busy stall", {75'd0, stall[1]}, '0);
    check("rst mid-busy outputs",
          {wb_out[1], m2r_out[1], data_out[1], alu_out[1], dst_out[1], mis_out[1],
           valid_out[1], 3'd0}, '0);
    rst[1] = 1'b0;
    issue(1, 1, 0, 1, 1, 32'h0C, 32'd0, 5'd3, 32'd0, 0, 1);
    issue(1, 0, 1, 0, 0, 32'h40, 32'h1111, 5'd0, 32'd0, 0, 1);
    issue(1, 0, 1, 0, 0, 32'h44, 32'h2222, 5'd0, 32'd0, 0, 1);
    issue(1, 1, 0, 1, 1, 32'h40, 32'd0, 5'd1, 32'h1111, 0, 1);
    issue(1, 1, 0, 1, 1, 32'h44, 32'd0, 5'd2, 32'h2222, 0, 1);
    issue(1, 1, 0, 1, 1, 32'h40, 32'd0, 5'd3, 32'h1111, 0, 1);
    idle(1);

    for (int k = 0; k < 60 && (exp_q0.size() != 0 || exp_q1.size() != 0); k++)
      @(negedge clk);
    check("drain pending", W'(exp_q0.size() + exp_q1.size()), '0);
    repeat (3) @(negedge clk);
    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
